sync_fifo_v2: RTL and testbench
===============================

# sync_fifo_v2

- Parametrised synchronous FIFO for single-clock datapaths.
- Generalises the original 16x32 FIFO:
  - parametrised width and depth;
  - all DEPTH entries usable;
  - occupancy count;
  - programmable almost-full / almost-empty thresholds;
  - sticky overflow/underflow error flags;
  - selectable standard (registered-read) or first-word-fall-through (FWFT) output mode.
- Sits between producer and consumer stages as the team's default buffering element.

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of entries; power of two, >= 4.
- AW, $clog2(DEPTH), derived pointer width; not to be overridden.
- FWFT, 0, output mode: 0 = standard registered read, 1 = first-word fall-through.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  write request.
- data_in  input  WIDTH  write data.
- rd_en  input  1  read request (FWFT: pop).
- data_out  output  WIDTH  read data.
- data_valid  output  1  standard mode: data_out updated by a read this cycle. FWFT: equals ~empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- half_full  output  1  count >= DEPTH/2.
- almost_full  output  1  count >= afull_thresh.
- almost_empty  output  1  count <= aempty_thresh.
- afull_thresh  input  AW+1  almost-full threshold; quasi-static.
- aempty_thresh  input  AW+1  almost-empty threshold; quasi-static.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- err_clr  input  1  synchronous clear of overflow and underflow.

## Operation
- Storage: DEPTH x WIDTH register array. wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
- count is an explicit AW+1-bit register. Full and empty are never inferred from pointer difference.
- Read acceptance: rd_acc = rd_en & ~empty.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments.
- Accepted read: rd_ptr increments.
- count update: +1 if wr_acc & ~rd_acc; -1 if rd_acc & ~wr_acc; otherwise unchanged.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1.
  - Otherwise data_valid <= 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally when ~empty; 0 when empty.
  - rd_en acknowledges (pops) the displayed word.
- Simultaneous read and write when empty: the read is rejected and underflow sets; the write is accepted.
- Simultaneous read and write when count = 1: both accepted. In FWFT, data_out shows the new word the next cycle.
- Error flags:
  - overflow <= 1 when wr_en & ~wr_acc.
  - underflow <= 1 when rd_en & ~rd_acc.
  - err_clr clears both; a new error event in the same cycle wins (flag stays 1).
- Status flags are decoded from registered count and thresholds only. No combinational path from wr_en/rd_en/data_in to any output.
- Thresholds: afull_thresh = 0 forces almost_full = 1. aempty_thresh >= DEPTH forces almost_empty = 1.
- Memory contents are not reset. After reset, only pointers, count, flags and data_out are defined.

## Timing
- Reset (rst_n low, asynchronous, immediate):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, half_full = 0.
  - almost_empty = 1 (given aempty_thresh >= 0), almost_full = (afull_thresh == 0).
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
- Reset mid-operation discards all contents. The first post-reset write is stored at entry 0.
- Write-to-flag latency: 1 cycle. A write at edge k updates count/empty/full after edge k.
- Standard-mode read latency: 1 cycle. rd_en sampled at edge k gives data_out/data_valid after edge k.
- FWFT latency: a word written at edge k into an empty FIFO appears on data_out after edge k.
- Throughput: one write and one read per cycle sustained, including at full and at empty with write-only.
- Error flags set at the edge following the offending request.

## Test plan
- Reset then fill: 16 writes of 0x0..0xF (DEPTH=16) -> count = 16, full = 1 after the 16th edge, half_full set after the 8th. A 17th write sets overflow, count stays 16.
- Drain, standard mode: 16 reads -> data_out 0x0..0xF in order, each 1 cycle after rd_en, data_valid pulsed. empty = 1 after the last. One more read sets underflow; data_out holds 0xF.
- Full with simultaneous rd_en & wr_en (data 0xAA) -> both accepted, count stays 16, no overflow. 0xAA emerges as the 16th subsequent read.
- FWFT=1: write 0x55 to an empty FIFO -> data_out = 0x55, empty = 0 next cycle. rd_en pops it; empty = 1 and data_out = 0 next cycle.
- Thresholds afull_thresh = 12, aempty_thresh = 3 -> almost_empty drops at count 4, almost_full rises at count 12. Pointer wrap over 40 mixed random operations matches the scoreboard.
- Assert rst_n low asynchronously with count = 9 and overflow = 1 -> all outputs take reset values immediately, before the next clock edge. Assert err_clr alone -> flags clear; err_clr with a simultaneous rejected write -> overflow stays 1.

Source files
------------

// File: rtl/sync_fifo_v2_if.sv
// Bundle of the FIFO's producer/consumer handshake, status and configuration
// signals. Keeping these together lets a stage hand one port to the buffer.
// The master side is the environment driving requests and thresholds.
// The slave side is the FIFO itself.
interface sync_fifo_v2_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             empty;
    logic             full;
    logic             half_full;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      afull_thresh;
    logic [AW:0]      aempty_thresh;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    modport master (
        output wr_en, data_in, rd_en, afull_thresh, aempty_thresh, err_clr,
        input  data_out, data_valid, empty, full, half_full, almost_full,
               almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, afull_thresh, aempty_thresh, err_clr,
        output data_out, data_valid, empty, full, half_full, almost_full,
               almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO. All DEPTH entries are usable.
// Occupancy is kept in an explicit counter, so full and empty are never
// derived from the pointer difference.
// Every status output is decoded from registered state only.
// The output stage is either a registered read or first-word fall-through.
module sync_fifo_v2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int FWFT  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    sync_fifo_v2_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic             udf_q;
    logic             empty_w;
    logic             full_w;
    logic             rd_acc;
    logic             wr_acc;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = bus.rd_en & ~empty_w;
    assign wr_acc = bus.wr_en & (~full_w | rd_acc);

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage array; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Sticky error flags. A fresh error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= (bus.wr_en & ~wr_acc) | (ovf_q & ~bus.err_clr);
            udf_q <= (bus.rd_en & ~rd_acc) | (udf_q & ~bus.err_clr);
        end
    end

    // A zero almost-full threshold or an almost-empty threshold at or above
    // DEPTH pins the corresponding flag high through the plain compares.
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.half_full    = (count_q >= HALF_CNT);
    assign bus.almost_full  = (count_q >= bus.afull_thresh);
    assign bus.almost_empty = (count_q <= bus.aempty_thresh);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

    if (FWFT != 0) begin : g_fwft
        // The head word is shown directly; it is forced to zero when empty so
        // stale memory never leaks onto the bus.
        assign bus.data_out   = empty_w ? '0 : mem[rd_ptr];
        assign bus.data_valid = ~empty_w;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        logic             dvalid_q;

        // Registered read: data_valid pulses for one cycle per accepted read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                dvalid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end
        end

        assign bus.data_out   = dout_q;
        assign bus.data_valid = dvalid_q;
    end
endmodule

// File: tb/tb_sync_fifo_v2.sv
// Bench for sync_fifo_v2. A standard-mode and a FWFT-mode instance receive
// identical stimulus. A queue-based reference model predicts occupancy,
// flags and read data. Monitors pop expected words whenever a DUT presents one.
`timescale 1ns/1ps
module tb_sync_fifo_v2;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_v2_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_s ();
    sync_fifo_v2_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_f ();

    sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_s)
    );

    sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_f)
    );

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] std_q[$];
    logic [WIDTH-1:0] fwft_q[$];
    bit               m_ovf;
    bit               m_udf;
    bit               m_dvalid;
    logic [WIDTH-1:0] m_dout;
    logic [AW:0]      afull_t;
    logic [AW:0]      aempty_t;
    int               tests;
    int               fails;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(bit wr, logic [WIDTH-1:0] din, bit rd, bit clr);
        bus_s.wr_en = wr;  bus_f.wr_en = wr;
        bus_s.data_in = din; bus_f.data_in = din;
        bus_s.rd_en = rd;  bus_f.rd_en = rd;
        bus_s.err_clr = clr; bus_f.err_clr = clr;
    endtask

    task automatic set_thresh(logic [AW:0] af, logic [AW:0] ae);
        afull_t = af;
        aempty_t = ae;
        bus_s.afull_thresh = af;  bus_f.afull_thresh = af;
        bus_s.aempty_thresh = ae; bus_f.aempty_thresh = ae;
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_dvalid = 1'b0;
        m_dout = '0;
    endtask

    task automatic check_status();
        int n;
        logic [WIDTH-1:0] head;
        n = model_q.size();
        head = (n > 0) ? model_q[0] : '0;
        chk("count_s", 64'(bus_s.count), 64'(n));
        chk("count_f", 64'(bus_f.count), 64'(n));
        chk("empty_s", 64'(bus_s.empty), 64'(n == 0));
        chk("empty_f", 64'(bus_f.empty), 64'(n == 0));
        chk("full_s", 64'(bus_s.full), 64'(n == DEPTH));
        chk("full_f", 64'(bus_f.full), 64'(n == DEPTH));
        chk("half_full_s", 64'(bus_s.half_full), 64'(n >= DEPTH / 2));
        chk("half_full_f", 64'(bus_f.half_full), 64'(n >= DEPTH / 2));
        chk("almost_full_s", 64'(bus_s.almost_full), 64'(n >= int'(afull_t)));
        chk("almost_full_f", 64'(bus_f.almost_full), 64'(n >= int'(afull_t)));
        chk("almost_empty_s", 64'(bus_s.almost_empty), 64'(n <= int'(aempty_t)));
        chk("almost_empty_f", 64'(bus_f.almost_empty), 64'(n <= int'(aempty_t)));
        chk("overflow_s", 64'(bus_s.overflow), 64'(m_ovf));
        chk("overflow_f", 64'(bus_f.overflow), 64'(m_ovf));
        chk("underflow_s", 64'(bus_s.underflow), 64'(m_udf));
        chk("underflow_f", 64'(bus_f.underflow), 64'(m_udf));
        chk("data_valid_s", 64'(bus_s.data_valid), 64'(m_dvalid));
        chk("data_out_s", 64'(bus_s.data_out), 64'(m_dout));
        chk("data_valid_f", 64'(bus_f.data_valid), 64'(n > 0));
        chk("data_out_f", 64'(bus_f.data_out), 64'(head));
    endtask

    // One clock of stimulus: drive on the falling edge, update the model with
    // the acceptance rules, then check status just after the rising edge.
    task automatic drive(bit wr, logic [WIDTH-1:0] din, bit rd, bit clr);
        bit rd_ok;
        bit wr_ok;
        logic [WIDTH-1:0] w;
        @(negedge clk);
        set_inputs(wr, din, rd, clr);
        rd_ok = rd && (model_q.size() > 0);
        wr_ok = wr && ((model_q.size() < DEPTH) || rd_ok);
        m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
        m_udf = (rd && !rd_ok) || (m_udf && !clr);
        m_dvalid = rd_ok;
        if (rd_ok) begin
            w = model_q.pop_front();
            m_dout = w;
            std_q.push_back(w);
            fwft_q.push_back(w);
        end
        if (wr_ok) begin
            model_q.push_back(din);
        end
        @(posedge clk);
        #1;
        set_inputs(1'b0, '0, 1'b0, 1'b0);
        check_status();
    endtask

    // Standard mode: each data_valid pulse must carry the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && bus_s.data_valid) begin
            if (std_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL std_read: got %0h with no word expected at %0t", bus_s.data_out, $time);
            end else begin
                chk("std_read", 64'(bus_s.data_out), 64'(std_q.pop_front()));
            end
        end
    end

    // FWFT mode: the word on data_out when a pop is acknowledged must be the oldest.
    always @(negedge clk) begin
        #3;
        if (rst_n && bus_f.rd_en && !bus_f.empty) begin
            if (fwft_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL fwft_pop: got %0h with no word expected at %0t", bus_f.data_out, $time);
            end else begin
                chk("fwft_pop", 64'(bus_f.data_out), 64'(fwft_q.pop_front()));
            end
        end
    end

    initial begin
        int wp;
        int rp;
        tests = 0;
        fails = 0;
        set_inputs(1'b0, '0, 1'b0, 1'b0);
        set_thresh(12, 3);
        model_reset();
        #12;
        check_status();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, then one extra write overflows.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        // Drain in order, then one extra read underflows and data_out holds.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Read+write on empty, then on a single entry.
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        drive(1'b1, 32'h88, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1);

        // FWFT single word in and out.
        drive(1'b1, 32'h55, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Full with simultaneous read and write, then clear racing a rejected write.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, WIDTH'(32'h100 + i), 1'b0, 1'b0);
        drive(1'b1, 32'hAA, 1'b1, 1'b0);
        drive(1'b1, 32'hBB, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Randomised traffic with shifting write/read bias to visit full and empty.
        for (int seg = 0; seg < 4; seg++) begin
            wp = (seg == 0) ? 85 : (seg == 1) ? 15 : 55;
            rp = (seg == 0) ? 15 : (seg == 1) ? 85 : 45;
            for (int i = 0; i < 50; i++) begin
                drive($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
                      $urandom_range(0, 99) < 5);
            end
        end

        // Threshold extremes pin almost_full and almost_empty high.
        drive(1'b0, '0, 1'b0, 1'b1);
        set_thresh(0, 5'(DEPTH));
        for (int i = 0; i < 40; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0, 1'b0);
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, '0, 1'b1, 1'b0);
        set_thresh(12, 3);

        // Build count 9 with overflow set, then reset asynchronously mid-cycle.
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, WIDTH'(32'h200 + i), 1'b0, 1'b0);
        drive(1'b1, 32'h3FF, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, '0, 1'b1, 1'b0);
        chk("pre_reset_count", 64'(bus_s.count), 64'd9);
        chk("pre_reset_overflow", 64'(bus_s.overflow), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_status();
        @(posedge clk);
        #1;
        check_status();
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset traffic starts from entry 0.
        drive(1'b1, 32'hC0DE, 1'b0, 1'b0);
        drive(1'b1, 32'hBEEF, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        @(negedge clk);
        #4;
        chk("std_q_drained", 64'(std_q.size()), 64'd0);
        chk("fwft_q_drained", 64'(fwft_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
